// File: rtl/inst_boot_loader.sv
// inst_boot_loader: packs a valid/ready beat stream into instruction words, writes them
// to instruction RAM from address 0, optionally verifies a trailing checksum word, then
// holds the processor out of reset for a bounded (or unbounded) run.
module inst_boot_loader #(
  parameter int INST_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int IN_WIDTH   = 8,
  parameter int RUN_CYCLES = 1024,
  parameter int CHECK_EN   = 1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [ADDR_WIDTH-1:0] Load_Len,
  input  logic                  In_Valid,
  input  logic [IN_WIDTH-1:0]   In_Data,
  output logic                  In_Ready,
  output logic                  Ram_Inst_Write,
  output logic [ADDR_WIDTH-1:0] Inst_Addr,
  output logic [INST_WIDTH-1:0] Ram_Inst_In,
  output logic                  Cpu_Reset,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Error
);

  localparam int BEATS = INST_WIDTH / IN_WIDTH;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int RW    = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;
  // Word counter is one bit wider so a full-capacity image never aliases address 0.
  localparam int CW    = ADDR_WIDTH + 1;
  localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);
  localparam logic [RW-1:0] RUN_LAST  = RW'((RUN_CYCLES > 0) ? RUN_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CHECK, S_RUN, S_DONE, S_ERROR
  } state_t;

  state_t                 state_reg, state_next;
  logic [BW-1:0]          beat_cnt_reg;
  logic [CW-1:0]          word_cnt_reg;
  logic [CW-1:0]          last_word_reg;
  logic [INST_WIDTH-1:0]  asm_reg;
  logic [INST_WIDTH-1:0]  checksum_reg;
  logic [RW-1:0]          run_cnt_reg;
  logic                   wr_reg;
  logic [ADDR_WIDTH-1:0]  addr_reg;
  logic [INST_WIDTH-1:0]  data_reg;
  logic                   cpu_reset_reg;

  logic                   accept;
  logic                   last_beat;
  logic                   word_done;
  logic                   start_ok;
  logic                   run_last;
  logic [INST_WIDTH-1:0]  full_word;

  assign accept    = In_Valid && In_Ready;
  assign last_beat = (beat_cnt_reg == BEAT_LAST);
  assign word_done = accept && last_beat;
  assign run_last  = !cpu_reset_reg && (run_cnt_reg == RUN_LAST);
  // Start is only honoured where no load or bounded run is in flight.
  assign start_ok  = Start && (state_reg == S_IDLE || state_reg == S_DONE ||
                               state_reg == S_ERROR ||
                               (state_reg == S_RUN && RUN_CYCLES == 0));

  // Current beat merged into its lane so a completed word is usable in the same cycle.
  genvar gi;
  generate
    for (gi = 0; gi < BEATS; gi++) begin : g_lane
      assign full_word[gi*IN_WIDTH +: IN_WIDTH] =
        (beat_cnt_reg == BW'(gi)) ? In_Data : asm_reg[gi*IN_WIDTH +: IN_WIDTH];
    end
  endgenerate

  // State register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  // Next-state decision.
  always_comb begin
    state_next = state_reg;
    if (start_ok) begin
      state_next = S_LOAD;
    end else begin
      case (state_reg)
        S_LOAD:  if (word_done && word_cnt_reg == last_word_reg)
                   state_next = (CHECK_EN != 0) ? S_CHECK : S_RUN;
        S_CHECK: if (word_done)
                   state_next = (full_word == checksum_reg) ? S_RUN : S_ERROR;
        S_RUN:   if (RUN_CYCLES != 0 && run_last) state_next = S_DONE;
        default: state_next = state_reg;
      endcase
    end
  end

  // State-decoded outputs.
  always_comb begin
    In_Ready = (state_reg == S_LOAD) || (state_reg == S_CHECK);
    Busy     = (state_reg == S_LOAD) || (state_reg == S_CHECK) || (state_reg == S_RUN);
    Done     = (state_reg == S_DONE);
    Error    = (state_reg == S_ERROR);
  end

  // Datapath: beat packing, RAM write port, checksum, run timer and processor reset.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      beat_cnt_reg  <= '0;
      word_cnt_reg  <= '0;
      last_word_reg <= '0;
      asm_reg       <= '0;
      checksum_reg  <= '0;
      run_cnt_reg   <= '0;
      wr_reg        <= 1'b0;
      addr_reg      <= '0;
      data_reg      <= '0;
      cpu_reset_reg <= 1'b1;
    end else begin
      wr_reg        <= 1'b0;
      // Released only once RUN has been occupied for a full cycle, and reasserted as
      // soon as RUN is left (bounded end or reload).
      cpu_reset_reg <= !(state_reg == S_RUN && state_next == S_RUN);
      if (start_ok) begin
        beat_cnt_reg  <= '0;
        word_cnt_reg  <= '0;
        asm_reg       <= '0;
        checksum_reg  <= '0;
        last_word_reg <= (Load_Len == '0) ? {1'b0, {ADDR_WIDTH{1'b1}}}
                                          : {1'b0, Load_Len - ADDR_WIDTH'(1)};
      end else if (accept) begin
        beat_cnt_reg <= last_beat ? '0 : beat_cnt_reg + BW'(1);
        asm_reg      <= full_word;
        if (last_beat && state_reg == S_LOAD) begin
          wr_reg       <= 1'b1;
          addr_reg     <= word_cnt_reg[ADDR_WIDTH-1:0];
          data_reg     <= full_word;
          checksum_reg <= checksum_reg + full_word;
          word_cnt_reg <= word_cnt_reg + CW'(1);
        end
      end
      if (state_reg != S_RUN)  run_cnt_reg <= '0;
      else if (!cpu_reset_reg) run_cnt_reg <= run_cnt_reg + RW'(1);
    end
  end

  assign Ram_Inst_Write = wr_reg;
  assign Inst_Addr      = addr_reg;
  assign Ram_Inst_In    = data_reg;
  assign Cpu_Reset      = cpu_reset_reg;

endmodule
